// File: rtl/hilo_mult_ctrl.sv
// HI/LO register pair and sequencer for the iterative unsigned multiplier.
// Optional feature macro: HILO_BYPASS_EN (forward the multiplier product to reads).
module hilo_mult_ctrl #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        mult_go,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_done,
  input  logic [63:0] mult_prod,
  output logic        mult_clr,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rdata,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        busy,
  output logic        start_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        rd_req;
  logic        fwd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mult_go     <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      mult_clr    <= 1'b0;
      start_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mult_clr  <= 1'b0;
      start_err <= start && (state != IDLE);
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
      case (state)
        IDLE: begin
          if (start) begin
            mult_a  <= op_a;
            mult_b  <= op_b;
            cnt     <= '0;
            mult_go <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mult_done) begin
            mult_go  <= 1'b0;
            mult_clr <= 1'b1;
            state    <= CAPT;
          end else if (cnt == 6'(TIMEOUT - 1)) begin
            mult_go     <= 1'b0;
            mult_clr    <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        CAPT: begin
          // Capture overrides any MTHI/MTLO landing on the same edge.
          hi    <= mult_prod[63:32];
          lo    <= mult_prod[31:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign rd_req = rd_hi | rd_lo;

`ifdef HILO_BYPASS_EN
  assign fwd = ((state == WAIT) && mult_done) || (state == CAPT);
`else
  assign fwd = 1'b0;
`endif

  always_comb begin
    stall = rd_req && busy && !fwd;
    if (fwd) rdata = rd_hi ? mult_prod[63:32] : mult_prod[31:0];
    else     rdata = rd_hi ? hi : lo;
  end

endmodule
